// File: rtl/sram_fifo_pkg.sv
// sram_fifo_pkg: shared constants and helpers for the SRAM-backed FIFO.
//   PRIO_WR / PRIO_RD : values of the write/read arbitration priority bit
//   OBUF_DEPTH_DEF    : default depth of the output buffer
//   level_w()         : width of the optional fill-level output
package sram_fifo_pkg;

    localparam logic PRIO_WR = 1'b0;
    localparam logic PRIO_RD = 1'b1;

    localparam int OBUF_DEPTH_DEF = 4;

    // Level counts SRAM words plus up to OBUF_DEPTH buffered/in-flight words,
    // so it needs one bit beyond the SRAM word counter.
    function automatic int level_w(input int aw);
        return aw + 2;
    endfunction

endpackage

// File: rtl/sram_fifo_if.sv
// sram_fifo_if: stream and arbiter-channel signals of sram_fifo.
//   s_data/s_valid/s_ready : input stream
//   m_data/m_valid/m_ready : output stream
//   addra/data_wr/ena/wea  : request to the SRAM arbiter
//   data_rd/valida/busya   : response/status from the SRAM arbiter
// Modport slave is the FIFO's view; master is the environment's view.
interface sram_fifo_if #(
    parameter int aw = 19,
    parameter int dw = 8
);
    logic [dw-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [dw-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic [aw-1:0] addra;
    logic [dw-1:0] data_wr;
    logic [dw-1:0] data_rd;
    logic          ena;
    logic          wea;
    logic          busya;
    logic          valida;

    modport slave (
        input  s_data, s_valid, m_ready, data_rd, busya, valida,
        output s_ready, m_data, m_valid, addra, data_wr, ena, wea
    );

    modport master (
        output s_data, s_valid, m_ready, data_rd, busya, valida,
        input  s_ready, m_data, m_valid, addra, data_wr, ena, wea
    );
endinterface

// File: rtl/sram_fifo_obuf.sv
// sram_fifo_obuf: small synchronous FIFO with a registered head word.
//   clk, rst : clock, synchronous active-high reset
//   i_push, i_data : write one word (caller guarantees not full)
//   i_pop    : remove head word (ignored when empty)
//   o_data   : registered head word, o_valid : not empty, o_cnt : occupancy
module sram_fifo_obuf #(
    parameter int DEPTH = 4,
    parameter int dw    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [dw-1:0]            i_data,
    input  logic                     i_pop,
    output logic [dw-1:0]            o_data,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_cnt
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    logic [dw-1:0] r_mem [DEPTH];
    logic [IW-1:0] r_wr_idx;
    logic [IW-1:0] r_rd_idx;
    logic [CW-1:0] r_cnt;
    logic [dw-1:0] r_head;

    logic          w_pop;
    logic [IW-1:0] w_rd_nxt;

    assign w_pop    = i_pop && (r_cnt != '0);
    assign w_rd_nxt = r_rd_idx + IW'(1);

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_idx] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_cnt    <= '0;
            r_head   <= '0;
        end else begin
            if (i_push) r_wr_idx <= r_wr_idx + IW'(1);
            if (w_pop)  r_rd_idx <= w_rd_nxt;
            case ({i_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
            // Head register tracks mem[rd_idx]; when the entry behind the
            // head is not yet stored, the incoming word becomes the head.
            if (w_pop) begin
                if (r_cnt > CW'(1)) begin
                    r_head <= r_mem[w_rd_nxt];
                end else if (i_push) begin
                    r_head <= i_data;
                end
            end else if (i_push && (r_cnt == '0)) begin
                r_head <= i_data;
            end
        end
    end

    assign o_data  = r_head;
    assign o_valid = (r_cnt != '0);
    assign o_cnt   = r_cnt;
endmodule

// File: rtl/sram_fifo.sv
// sram_fifo: deep FIFO using single-port SRAM behind an arbiter channel.
//   clk, rst : clock, synchronous active-high reset
//   bus      : sram_fifo_if.slave (input stream, output stream, arbiter port)
//   o_level, o_full : fill level and full flag, only when the macro
//                     SRAM_FIFO_STATUS_EN is defined
// Writes and reads share the SRAM; when both want it, grants alternate.
// Reads are only issued when a slot in the output buffer is reserved for
// the returning word (in-flight + buffered < OBUF_DEPTH).
module sram_fifo
    import sram_fifo_pkg::*;
#(
    parameter int aw         = 19,
    parameter int dw         = 8,
    parameter int latency    = 1,
    parameter int OBUF_DEPTH = OBUF_DEPTH_DEF
) (
    input  logic clk,
    input  logic rst,
    sram_fifo_if.slave bus
`ifdef SRAM_FIFO_STATUS_EN
    ,
    output logic [level_w(aw)-1:0] o_level,
    output logic                   o_full
`endif
);
    localparam int CW = $clog2(OBUF_DEPTH) + 1;

    if (OBUF_DEPTH < latency + 2 || (OBUF_DEPTH & (OBUF_DEPTH - 1)) != 0) begin : g_cfg_err
        $error("sram_fifo: OBUF_DEPTH must be a power of two and >= latency+2");
    end

    logic [aw-1:0] r_wr_ptr;
    logic [aw-1:0] r_rd_ptr;
    logic [aw:0]   r_words;
    logic [CW-1:0] r_inflight;
    logic          r_prio;
    logic          r_rd_live;   // returning data accepted only after a post-reset request
    logic [aw-1:0] r_addra;
    logic [dw-1:0] r_data_wr;
    logic          r_ena;
    logic          r_wea;

    logic [CW-1:0] w_obuf_cnt;
    logic [dw-1:0] w_obuf_data;
    logic          w_obuf_valid;
    logic [CW:0]   w_credit_used;
    logic          w_wr_want;
    logic          w_rd_want;
    logic          w_wr_cand;
    logic          w_wr_sel;
    logic          w_rd_sel;
    logic          w_push;
    logic          w_pop;

    assign w_credit_used = {1'b0, r_inflight} + {1'b0, w_obuf_cnt};
    assign w_wr_want     = !r_words[aw];
    assign w_rd_want     = (r_words != '0) && (w_credit_used < (CW+1)'(OBUF_DEPTH));
    assign w_wr_cand     = bus.s_valid && w_wr_want;
    assign w_wr_sel      = !bus.busya && w_wr_cand && (!w_rd_want || r_prio == PRIO_WR);
    assign w_rd_sel      = !bus.busya && w_rd_want && (!w_wr_cand || r_prio == PRIO_RD);
    assign w_push        = bus.valida && r_rd_live;
    assign w_pop         = bus.m_valid && bus.m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_words    <= '0;
            r_inflight <= '0;
            r_prio     <= PRIO_WR;
            r_rd_live  <= 1'b0;
            r_addra    <= '0;
            r_data_wr  <= '0;
            r_ena      <= 1'b0;
            r_wea      <= 1'b0;
        end else begin
            if (w_wr_sel) begin
                r_addra   <= r_wr_ptr;
                r_data_wr <= bus.s_data;
                r_wea     <= 1'b1;
                r_ena     <= 1'b1;
                r_wr_ptr  <= r_wr_ptr + aw'(1);
                r_words   <= r_words + (aw+1)'(1);
            end else if (w_rd_sel) begin
                r_addra   <= r_rd_ptr;
                r_wea     <= 1'b0;
                r_ena     <= 1'b1;
                r_rd_ptr  <= r_rd_ptr + aw'(1);
                r_words   <= r_words - (aw+1)'(1);
            end else begin
                r_ena     <= 1'b0;
                r_wea     <= 1'b0;
            end

            case ({w_rd_sel, w_push})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: r_inflight <= r_inflight;
            endcase

            // Contention resolved by alternating: flip only when both sides
            // competed and one of them was actually granted.
            if (w_wr_cand && w_rd_want && !bus.busya) begin
                r_prio <= ~r_prio;
            end

            if (w_wr_sel || w_rd_sel) begin
                r_rd_live <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(w_push && w_obuf_cnt == CW'(OBUF_DEPTH)));
        end
    end

    sram_fifo_obuf #(
        .DEPTH (OBUF_DEPTH),
        .dw    (dw)
    ) u_obuf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (bus.data_rd),
        .i_pop   (w_pop),
        .o_data  (w_obuf_data),
        .o_valid (w_obuf_valid),
        .o_cnt   (w_obuf_cnt)
    );

    assign bus.s_ready = w_wr_sel && !rst;
    assign bus.m_valid = w_obuf_valid && !rst;
    assign bus.m_data  = w_obuf_data;
    assign bus.addra   = r_addra;
    assign bus.data_wr = r_data_wr;
    assign bus.ena     = r_ena;
    assign bus.wea     = r_wea;

`ifdef SRAM_FIFO_STATUS_EN
    localparam int LW = level_w(aw);
    logic [LW-1:0] r_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= '0;
        end else begin
            r_level <= LW'(r_words) + LW'(r_inflight) + LW'(w_obuf_cnt);
        end
    end

    assign o_level = r_level;
    assign o_full  = (r_level == LW'((2 ** aw) + OBUF_DEPTH));
`endif
endmodule

// File: tb/tb_sram_fifo.sv
// tb_sram_fifo: randomized scoreboard bench for sram_fifo (aw=4, dw=8).
// A behavioural SRAM/arbiter with one cycle read latency answers requests;
// accepted input words are queued as expected output, a monitor pops and
// compares each delivered word. Status ports exist with SRAM_FIFO_STATUS_EN.
module tb_sram_fifo;
    localparam int AW  = 4;
    localparam int DW  = 8;
    localparam int LAT = 1;
    localparam int OD  = 4;
    localparam int CAP = (2 ** AW) + OD;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_fifo_if #(.aw(AW), .dw(DW)) bus ();

`ifdef SRAM_FIFO_STATUS_EN
    logic [AW+1:0] level;
    logic          full;
`endif

    sram_fifo #(
        .aw         (AW),
        .dw         (DW),
        .latency    (LAT),
        .OBUF_DEPTH (OD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef SRAM_FIFO_STATUS_EN
        ,
        .o_level (level),
        .o_full  (full)
`endif
    );

    // ---------------- SRAM + arbiter model ----------------
    logic [DW-1:0] sram [2**AW];
    logic          arb_v = 1'b0;
    logic [DW-1:0] arb_d = '0;
    logic          inj_v = 1'b0;
    logic [DW-1:0] inj_d = '0;

    initial begin
        for (int i = 0; i < 2**AW; i++) sram[i] = '0;
    end

    always @(posedge clk) begin
        arb_v <= bus.ena && !bus.wea;
        arb_d <= sram[bus.addra];
        if (bus.ena && bus.wea) sram[bus.addra] <= bus.data_wr;
    end

    assign bus.valida  = arb_v | inj_v;
    assign bus.data_rd = inj_v ? inj_d : arb_d;

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q [$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Output monitor
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (!rst && bus.m_valid && bus.m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected got=%02h want=none", bus.m_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.m_data !== e) begin
                    errors++;
                    $display("FAIL out_data got=%02h want=%02h", bus.m_data, e);
                end else begin
                    $display("OUT  data=%02h", bus.m_data);
                end
            end
        end
    end

    // Write-address monitor: the n-th write since reset targets n mod 2**aw
    int wr_cnt = 0;
    int wrap_cnt = 0;
    always @(negedge clk) begin
        if (rst) begin
            wr_cnt = 0;
        end else if (bus.ena && bus.wea) begin
            checks++;
            if (int'(bus.addra) != (wr_cnt % (2**AW))) begin
                errors++;
                $display("FAIL wr_addr got=%0d want=%0d", bus.addra, wr_cnt % (2**AW));
            end
            if (wr_cnt > 0 && bus.addra == '0) wrap_cnt++;
            wr_cnt++;
        end
    end

    // ---------------- driver ----------------
    logic smp_ena, smp_wea, smp_mv, smp_srdy;

    task automatic drive_cycle(input logic v, input logic [DW-1:0] d, input logic mr,
                               input logic busy, output logic acc);
        bus.s_valid = v;
        bus.s_data  = d;
        bus.m_ready = mr;
        bus.busya   = busy;
        @(negedge clk);
        smp_ena  = bus.ena;
        smp_wea  = bus.wea;
        smp_mv   = bus.m_valid;
        smp_srdy = bus.s_ready;
        acc = v && bus.s_ready;
        if (acc) begin
            exp_q.push_back(d);
            $display("IN   data=%02h", d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) break;
            drive_cycle(1'b0, '0, 1'b1, 1'b0, acc);
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic acc;
        int lat, n;
        logic prev_wea;

        rst = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        bus.busya   = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_s_ready", bus.s_ready, 0);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_data",  bus.m_data, 0);
        chk("rst_ena",     bus.ena, 0);
        chk("rst_wea",     bus.wea, 0);
        chk("rst_addra",   bus.addra, 0);
        chk("rst_data_wr", bus.data_wr, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: minimum latency and in-order delivery
        drive_cycle(1'b1, 8'h11, 1'b1, 1'b0, acc);
        chk("first_accept", acc, 1);
        lat = 99;
        for (int k = 1; k <= 10; k++) begin
            drive_cycle(1'b0, '0, 1'b1, 1'b0, acc);
            if (smp_mv) begin
                lat = k;
                break;
            end
        end
        chk("first_latency", lat, 4);
        for (int i = 2; i <= 4; i++) drive_cycle(1'b1, DW'(8'h10 + i), 1'b1, 1'b0, acc);
        drain();

        // 2: total capacity with output stalled
        n = 0;
        for (int i = 0; i < 40; i++) begin
            drive_cycle(1'b1, DW'(8'h20 + i), 1'b0, 1'b0, acc);
            if (acc) n++;
        end
        chk("capacity", n, CAP);
        drive_cycle(1'b1, 8'hEE, 1'b0, 1'b0, acc);
        chk("full_s_ready", acc, 0);
`ifdef SRAM_FIFO_STATUS_EN
        chk("full_level", level, CAP);
        chk("full_flag", full, 1);
`endif

        // 3: sustained traffic alternates write/read grants every cycle
        n = 0;
        for (int i = 0; i < 12; i++) begin
            drive_cycle(1'b1, DW'(8'h40 + n), 1'b1, 1'b0, acc);
            if (acc) n++;
        end
        prev_wea = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b1, DW'(8'h40 + n), 1'b1, 1'b0, acc);
            if (acc) n++;
            chk("alt_ena", smp_ena, 1);
            if (i > 0) chk("alt_wea", smp_wea, int'(!prev_wea));
            prev_wea = smp_wea;
        end

        // 4: busya stall mid-stream
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, DW'(8'h40 + n), 1'b1, 1'b1, acc);
            if (acc) n++;
            chk("busy_s_ready", smp_srdy, 0);
            if (i > 0) chk("busy_ena", smp_ena, 0);
        end
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b1, DW'(8'h40 + n), 1'b1, 1'b0, acc);
            if (acc) n++;
        end
        drain();

        // 5: 40 incrementing words, random valid/ready
        n = 0;
        for (int i = 0; i < 400 && n < 40; i++) begin
            drive_cycle(logic'($urandom_range(0, 3) != 0), DW'(8'h80 + n),
                        logic'($urandom_range(0, 1)), 1'b0, acc);
            if (acc) n++;
        end
        chk("stream40_accepted", n, 40);
        drain();
        chk("addr_wrapped", int'(wrap_cnt >= 2), 1);

        // 6: reset with reads in flight, stale return data ignored
        for (int i = 0; i < 10; i++) drive_cycle(1'b1, DW'(8'h60 + i), 1'b0, 1'b0, acc);
        drive_cycle(1'b0, '0, 1'b1, 1'b0, acc);
        drive_cycle(1'b0, '0, 1'b1, 1'b0, acc);
        rst = 1'b1;
        exp_q.delete();
        bus.s_valid = 1'b1;
        bus.m_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_m_valid", bus.m_valid, 0);
        chk("mid_rst_s_ready", bus.s_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        inj_v = 1'b1;
        inj_d = 8'h5A;
        drive_cycle(1'b0, '0, 1'b1, 1'b0, acc);
        inj_v = 1'b0;
        chk("post_rst_m_valid0", smp_mv, 0);
        drive_cycle(1'b0, '0, 1'b1, 1'b0, acc);
        chk("post_rst_m_valid1", smp_mv, 0);
        drive_cycle(1'b0, '0, 1'b1, 1'b0, acc);
        chk("post_rst_m_valid2", smp_mv, 0);
`ifdef SRAM_FIFO_STATUS_EN
        chk("post_rst_level", level, 0);
`endif
        drive_cycle(1'b1, 8'hA5, 1'b1, 1'b0, acc);
        chk("post_rst_accept", acc, 1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
